// File: rtl/flt_rom_stream_sequencer_pkg.sv
// Shared types and helpers for the ROM-driven AXI-Stream stimulus sequencer.
package flt_rom_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    // Gap counter must hold GAP_CYCLES-1; keep at least one bit for GAP_CYCLES=0.
    function automatic int gap_cnt_w(input int gap_cycles);
        int w;
        w = $clog2(gap_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flt_rom_stream_sequencer_if.sv
// AXI-Stream style beat channel between the sequencer and the floating-point core input.
interface flt_rom_stream_sequencer_if #(
    parameter int TUSER_W = 4
);
    // A beat transfers on a rising edge where tvalid & tready; once tvalid is high,
    // tvalid/tlast/tuser (and the ROM data) hold until that transfer happens.
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;

    modport master (output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/flt_rom_stream_sequencer.sv
// Walks a synchronous vector ROM (addr 0..DEPTH-1) and emits stream beats aligned with
// the ROM's one-cycle read latency, with frame index in tuser and optional idle gaps.
module flt_rom_stream_sequencer
    import flt_rom_seq_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 11,
    parameter int GAP_CYCLES = 1,
    parameter int TUSER_W    = 4,
    parameter int CONTINUOUS = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    flt_rom_stream_sequencer_if.master        m_axis,
    output logic                              rom_en,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic                              busy,
    output logic                              frame_done,
    output seq_state_e                        dbg_state
);

    localparam int                GAP_W     = gap_cnt_w(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must be in 1..2**ADDR_W");
    end
    if (TUSER_W < 1) begin : g_bad_tuser
        $error("TUSER_W must be at least 1");
    end

    seq_state_e          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_tvalid;
    logic                r_tlast;
    logic [TUSER_W-1:0]  r_tuser;
    logic [TUSER_W-1:0]  r_frame_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_stop_pend;
    logic                r_frame_done;

    logic                w_adv;
    logic                w_issue;
    logic                w_last_hs;
    logic                w_stop;
    logic                w_at_last;
    logic [TUSER_W-1:0]  w_frame_cur;

    assign w_adv     = !r_tvalid || m_axis.tready;
    assign w_issue   = w_adv && (r_state == RUN);
    assign w_last_hs = r_tvalid && m_axis.tready && r_tlast;
    assign w_stop    = r_stop_pend || stop;
    assign w_at_last = (r_addr == LAST_ADDR);
    // A frame's first beat can issue in the same cycle the previous tlast transfers.
    assign w_frame_cur = w_last_hs ? r_frame_cnt + TUSER_W'(1) : r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= '0;
            r_frame_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_stop_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_hs;
            if (w_last_hs) r_frame_cnt <= r_frame_cnt + TUSER_W'(1);

            if (w_adv) begin
                r_tvalid <= w_issue;
                r_tlast  <= w_issue && w_at_last;
                if (w_issue) r_tuser <= w_frame_cur;
            end

            case (r_state)
                IDLE: begin
                    r_stop_pend <= 1'b0;
                    r_addr      <= '0;
                    if (start && !stop) r_state <= RUN;
                end
                RUN: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (w_issue) begin
                        if (w_at_last) begin
                            r_addr <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_state   <= GAP;
                                r_gap_cnt <= GAP_LOAD;
                            end else if (CONTINUOUS != 0 && !w_stop) begin
                                r_state <= RUN;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (r_gap_cnt == '0) begin
                        r_state <= (CONTINUOUS != 0 && !w_stop) ? RUN : IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_en        = w_adv;
    assign rom_addr      = r_addr;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tuser  = r_tuser;
    assign busy          = (r_state != IDLE);
    assign frame_done    = r_frame_done;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_flt_rom_stream_sequencer.sv
// Directed bench: default continuous config, single-shot gapless config, and DEPTH=1 config.
module tb_flt_rom_stream_sequencer;
    import flt_rom_seq_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] user;
        int         cyc;
    } beat_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: defaults (DEPTH 11, gap 1, continuous)
    logic rst_n_a = 1'b0, start_a = 1'b0, stop_a = 1'b0;
    logic rom_en_a, busy_a, fd_a;
    logic [3:0] addr_a;
    logic [7:0] dout_a;
    seq_state_e st_a;
    flt_rom_stream_sequencer_if #(.TUSER_W(4)) if_a ();
    flt_rom_stream_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .stop(stop_a), .m_axis(if_a),
        .rom_en(rom_en_a), .rom_addr(addr_a), .busy(busy_a), .frame_done(fd_a), .dbg_state(st_a));

    // Instance B: single-shot, no gap
    logic rst_n_b = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic rom_en_b, busy_b, fd_b;
    logic [3:0] addr_b;
    logic [7:0] dout_b;
    seq_state_e st_b;
    flt_rom_stream_sequencer_if #(.TUSER_W(4)) if_b ();
    flt_rom_stream_sequencer #(.GAP_CYCLES(0), .CONTINUOUS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .stop(stop_b), .m_axis(if_b),
        .rom_en(rom_en_b), .rom_addr(addr_b), .busy(busy_b), .frame_done(fd_b), .dbg_state(st_b));

    // Instance C: DEPTH 1, 2-bit tuser
    logic rst_n_c = 1'b0, start_c = 1'b0, stop_c = 1'b0;
    logic rom_en_c, busy_c, fd_c;
    logic [3:0] addr_c;
    logic [7:0] dout_c;
    seq_state_e st_c;
    flt_rom_stream_sequencer_if #(.TUSER_W(2)) if_c ();
    flt_rom_stream_sequencer #(.DEPTH(1), .TUSER_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n_c), .start(start_c), .stop(stop_c), .m_axis(if_c),
        .rom_en(rom_en_c), .rom_addr(addr_c), .busy(busy_c), .frame_done(fd_c), .dbg_state(st_c));

    // Vector ROM models: data = 0x30 + address
    always @(posedge clk) if (rom_en_a) dout_a <= {4'h3, addr_a};
    always @(posedge clk) if (rom_en_b) dout_b <= {4'h3, addr_b};
    always @(posedge clk) if (rom_en_c) dout_c <= {4'h3, addr_c};

    beat_t beats_a[$];
    beat_t beats_b[$];
    beat_t beats_c[$];
    int    fd_cnt_b = 0;
    int    addr_bad_a = 0;

    always @(negedge clk) begin
        if (rst_n_a && if_a.tvalid && if_a.tready)
            beats_a.push_back('{dout_a, if_a.tlast, if_a.tuser, cyc});
        if (rst_n_b && if_b.tvalid && if_b.tready)
            beats_b.push_back('{dout_b, if_b.tlast, if_b.tuser, cyc});
        if (rst_n_c && if_c.tvalid && if_c.tready)
            beats_c.push_back('{dout_c, if_c.tlast, {2'b00, if_c.tuser}, cyc});
        if (fd_b) fd_cnt_b++;
        if (rst_n_a && addr_a > 4'd10) addr_bad_a++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        bit stall_done = 0;
        bit stop_done  = 0;
        bit found;

        if_a.tready = 1'b1;
        if_b.tready = 1'b1;
        if_c.tready = 1'b1;
        repeat (3) step();

        check_eq("rst_tvalid", if_a.tvalid, 0);
        check_eq("rst_tlast", if_a.tlast, 0);
        check_eq("rst_tuser", if_a.tuser, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_rom_addr", addr_a, 0);
        check_eq("rst_frame_done", fd_a, 0);

        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        step();

        // ---- A: latency, backpressure, stop in second frame
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("a_busy_after_start", busy_a, 1);
        check_eq("a_no_valid_at_entry", if_a.tvalid, 0);
        step();
        check_eq("a_first_valid", if_a.tvalid, 1);
        check_eq("a_first_data", dout_a, 8'h30);
        check_eq("a_first_tuser", if_a.tuser, 0);

        for (int i = 0; i < 400 && !(stop_done && !busy_a); i++) begin
            if (!stall_done && if_a.tvalid && dout_a == 8'h35) begin
                stall_done = 1;
                if_a.tready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check_eq("a_stall_valid", if_a.tvalid, 1);
                    check_eq("a_stall_data", dout_a, 8'h35);
                    check_eq("a_stall_rom_en", rom_en_a, 0);
                end
                check_eq("a_stall_tuser", if_a.tuser, 0);
                if_a.tready = 1'b1;
            end
            if (!stop_done && beats_a.size() == 14) begin
                stop_a = 1'b1;
                step();
                stop_a = 1'b0;
                stop_done = 1;
            end else begin
                step();
            end
        end
        check_eq("a_stall_seen", stall_done, 1);
        check_eq("a_stop_to_idle", busy_a, 0);
        check_eq("a_beat_count", beats_a.size(), 22);
        for (int i = 0; i < beats_a.size() && i < 22; i++) begin
            check_eq($sformatf("a_data_%0d", i), beats_a[i].data, 32'h30 + i % 11);
            check_eq($sformatf("a_last_%0d", i), beats_a[i].last, (i % 11) == 10);
            check_eq($sformatf("a_user_%0d", i), beats_a[i].user, i / 11);
        end
        if (beats_a.size() >= 13) begin
            check_eq("a_frame_gap", beats_a[11].cyc - beats_a[10].cyc, 2);
            check_eq("a_back_to_back", beats_a[12].cyc - beats_a[11].cyc, 1);
        end
        repeat (20) step();
        check_eq("a_no_beats_after_stop", beats_a.size(), 22);
        check_eq("a_idle_tvalid", if_a.tvalid, 0);

        start_a = 1'b1; stop_a = 1'b1;
        step();
        start_a = 1'b0; stop_a = 1'b0;
        check_eq("a_start_stop_busy", busy_a, 0);
        repeat (3) step();
        check_eq("a_start_stop_tvalid", if_a.tvalid, 0);
        check_eq("a_start_stop_beats", beats_a.size(), 22);
        check_eq("a_addr_range", addr_bad_a, 0);

        // ---- A: reset in the middle of backpressure
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (if_a.tvalid && dout_a == 8'h37) found = 1;
            else step();
        end
        check_eq("a_beat7_seen", found, 1);
        check_eq("a_beat7_tuser", if_a.tuser, 2);
        if_a.tready = 1'b0;
        step();
        step();
        rst_n_a = 1'b0;
        #1;
        check_eq("a_midrst_tvalid", if_a.tvalid, 0);
        check_eq("a_midrst_tlast", if_a.tlast, 0);
        check_eq("a_midrst_tuser", if_a.tuser, 0);
        check_eq("a_midrst_busy", busy_a, 0);
        check_eq("a_midrst_addr", addr_a, 0);
        check_eq("a_midrst_fd", fd_a, 0);
        step();
        rst_n_a = 1'b1;
        if_a.tready = 1'b1;
        beats_a.delete();
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 20 && beats_a.size() == 0; i++) step();
        check_eq("a_post_rst_beat_seen", beats_a.size() != 0, 1);
        if (beats_a.size() != 0) begin
            check_eq("a_post_rst_data", beats_a[0].data, 8'h30);
            check_eq("a_post_rst_user", beats_a[0].user, 0);
        end
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;

        // ---- B: single-shot, gapless
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 60 && busy_b; i++) step();
        check_eq("b_busy_drop", busy_b, 0);
        repeat (5) step();
        check_eq("b_beat_count", beats_b.size(), 11);
        for (int i = 0; i < beats_b.size() && i < 11; i++) begin
            check_eq($sformatf("b_data_%0d", i), beats_b[i].data, 32'h30 + i);
            check_eq($sformatf("b_last_%0d", i), beats_b[i].last, i == 10);
        end
        check_eq("b_frame_done_once", fd_cnt_b, 1);
        check_eq("b_idle_tvalid", if_b.tvalid, 0);
        for (int i = 0; i < 10; i++) begin
            if_b.tready = i[0];
            step();
        end
        if_b.tready = 1'b1;
        check_eq("b_tready_ignored", beats_b.size(), 11);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 60 && busy_b; i++) step();
        repeat (5) step();
        check_eq("b_second_count", beats_b.size(), 22);
        if (beats_b.size() >= 22) begin
            check_eq("b_second_user", beats_b[11].user, 1);
            check_eq("b_second_last", beats_b[21].last, 1);
        end
        check_eq("b_frame_done_twice", fd_cnt_b, 2);

        // ---- C: DEPTH 1, tuser wraps at 4
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 100 && beats_c.size() < 5; i++) step();
        stop_c = 1'b1;
        step();
        stop_c = 1'b0;
        for (int i = 0; i < 20 && busy_c; i++) step();
        check_eq("c_stop_idle", busy_c, 0);
        check_eq("c_enough_beats", beats_c.size() >= 5, 1);
        for (int i = 0; i < beats_c.size() && i < 5; i++) begin
            check_eq($sformatf("c_last_%0d", i), beats_c[i].last, 1);
            check_eq($sformatf("c_user_%0d", i), beats_c[i].user, i % 4);
            check_eq($sformatf("c_data_%0d", i), beats_c[i].data, 8'h30);
        end
        check_eq("c_addr_zero", addr_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
